display_uart_tx: RTL and testbench

DISPLAY_UART_TX -- requirements
Module: display_uart_tx

---
 rtl/display_uart_tx_pkg.sv | 20 ++
 rtl/display_uart_tx_baud_tick_gen.sv | 30 +++
 rtl/display_uart_tx.sv | 156 +++++++++++++++
 tb/tb_display_uart_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/display_uart_tx_pkg.sv
// Shared definitions for the DDR-to-UART display transmitter: FSM states,
// DSR status words and frame geometry.
package display_uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    // DSR bit 15 is the "ready" flag seen by the CPU; all other bits are zero.
    localparam logic [15:0] DSR_READY = 16'h8000;
    localparam logic [15:0] DSR_BUSY  = 16'h0000;

    // Start bit + 8 data bits + stop bit.
    localparam int FRAME_BITS = 10;

endpackage

// File: rtl/display_uart_tx_baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit period. Holding i_clear keeps the counter at 0 so the first bit
// after the clear lasts a full period.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam logic [15:0] LAST_COUNT = 16'(CLKS_PER_BIT - 1);

    logic [15:0] r_count;

    // Free-running period counter, wrapping at the bit boundary.
    always_ff @(posedge i_Clk) begin
        if (i_Rst || i_clear) begin
            r_count <= 16'd0;
        end else if (r_count == LAST_COUNT) begin
            r_count <= 16'd0;
        end else begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_tick = (r_count == LAST_COUNT) && !i_clear;

endmodule

// File: rtl/display_uart_tx.sv
// Display device for a small CPU: a store to DDR is serialised as one 8N1
// UART frame (LSB first, idle high). The DSR is driven through an external
// load strobe: not-ready when a byte is taken, ready when its frame ends.
// Handshake: i_ld_ddr is a one-cycle request; it is accepted only in IDLE or
// in the final stop-bit cycle, otherwise it is dropped and o_overrun latches.
module display_uart_tx
    import display_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_ld_ddr,
    input  logic [7:0]  i_ddr,
    output logic [15:0] o_dsr_ext,
    output logic        o_ld_dsr_ext,
    output logic        o_tx,
    output logic        o_busy,
    output logic        o_overrun
);

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_shift;
    logic [7:0]  w_next_shift;
    logic [2:0]  r_bit_idx;
    logic [2:0]  w_next_bit_idx;
    logic [2:0]  w_bit_idx_inc;
    logic        r_tx;
    logic        w_next_tx;
    logic        r_busy;
    logic        r_overrun;
    logic        w_next_overrun;
    logic [15:0] r_dsr;
    logic [15:0] w_next_dsr;
    logic        r_ld_dsr;
    logic        w_next_ld_dsr;
    logic        w_tick;
    logic        w_baud_clear;
    logic        w_last_stop;

    // The counter is parked while no frame is running, so it is at 0 on the
    // first START cycle.
    assign w_baud_clear  = (r_state == ST_IDLE) || (r_state == ST_CAPTURE);
    assign w_bit_idx_inc = r_bit_idx + 3'd1;
    assign w_last_stop   = (r_state == ST_STOP) && w_tick;

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_clear (w_baud_clear),
        .o_tick  (w_tick)
    );

    // Next-state and next-output logic; o_tx is computed one cycle ahead so
    // the line changes exactly at the state transition.
    always_comb begin
        w_next_state   = r_state;
        w_next_shift   = r_shift;
        w_next_bit_idx = r_bit_idx;
        w_next_tx      = r_tx;
        w_next_overrun = r_overrun;
        w_next_dsr     = r_dsr;
        w_next_ld_dsr  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_next_tx = 1'b1;
                if (i_ld_ddr) begin
                    w_next_state  = ST_CAPTURE;
                    w_next_ld_dsr = 1'b1;
                    w_next_dsr    = DSR_BUSY;
                end
            end
            ST_CAPTURE: begin
                // DDR data is valid one cycle after the store strobe.
                w_next_shift   = i_ddr;
                w_next_bit_idx = 3'd0;
                w_next_tx      = 1'b0;
                w_next_state   = ST_START;
            end
            ST_START: begin
                if (w_tick) begin
                    w_next_state = ST_DATA;
                    w_next_tx    = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == 3'd7) begin
                        w_next_state = ST_STOP;
                        w_next_tx    = 1'b1;
                    end else begin
                        w_next_bit_idx = w_bit_idx_inc;
                        w_next_tx      = r_shift[w_bit_idx_inc];
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    w_next_ld_dsr = 1'b1;
                    if (i_ld_ddr) begin
                        // Back-to-back store: the ready pulse is replaced
                        // by the not-ready pulse for the new byte.
                        w_next_state = ST_CAPTURE;
                        w_next_dsr   = DSR_BUSY;
                    end else begin
                        w_next_state = ST_IDLE;
                        w_next_dsr   = DSR_READY;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_tx    = 1'b1;
            end
        endcase

        // A store arriving while a frame is busy is dropped.
        if (i_ld_ddr && (r_state != ST_IDLE) && !w_last_stop) begin
            w_next_overrun = 1'b1;
        end
    end

    // State and registered outputs; reset re-initialises DSR to ready.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= 8'd0;
            r_bit_idx <= 3'd0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            r_dsr     <= DSR_READY;
            r_ld_dsr  <= 1'b1;
        end else begin
            r_state   <= w_next_state;
            r_shift   <= w_next_shift;
            r_bit_idx <= w_next_bit_idx;
            r_tx      <= w_next_tx;
            r_busy    <= (w_next_state != ST_IDLE);
            r_overrun <= w_next_overrun;
            r_dsr     <= w_next_dsr;
            r_ld_dsr  <= w_next_ld_dsr;
        end
    end

    assign o_tx         = r_tx;
    assign o_busy       = r_busy;
    assign o_overrun    = r_overrun;
    assign o_dsr_ext    = r_dsr;
    assign o_ld_dsr_ext = r_ld_dsr;

endmodule

// File: tb/tb_display_uart_tx.sv
// Bench for display_uart_tx with CLKS_PER_BIT=4. The driver keeps a
// timeline model (when each accepted frame ends) and pushes expected DSR
// strobes and UART frames; independent monitors decode the serial line and
// the strobe output and compare against the queues.
module tb_display_uart_tx;
  import display_uart_tx_pkg::*;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic        i_Clk = 1'b0;
  logic        i_Rst = 1'b1;
  logic        i_ld_ddr = 1'b0;
  logic [7:0]  i_ddr = 8'h00;
  logic [15:0] o_dsr_ext;
  logic        o_ld_dsr_ext;
  logic        o_tx;
  logic        o_busy;
  logic        o_overrun;

  display_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clk        (i_Clk),
    .i_Rst        (i_Rst),
    .i_ld_ddr     (i_ld_ddr),
    .i_ddr        (i_ddr),
    .o_dsr_ext    (o_dsr_ext),
    .o_ld_dsr_ext (o_ld_dsr_ext),
    .o_tx         (o_tx),
    .o_busy       (o_busy),
    .o_overrun    (o_overrun)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 i_Clk = ~i_Clk;

  int   cyc = 0;
  logic rst_at_edge = 1'b1;
  always @(posedge i_Clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= i_Rst;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passes = 0;

  int          exp_st_cyc[$];
  logic [15:0] exp_st_q[$];
  int          exp_fr_cyc[$];
  logic [7:0]  exp_q[$];

  // reference model state
  int   last_stop  = -1;
  logic overrun_m  = 1'b0;
  logic prev_wr    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  // One cycle of stimulus; the model decides acceptance from the frame
  // timeline: a store is taken if the previous frame has ended or this is
  // its last stop-bit cycle.
  task automatic step(input logic wr, input logic [7:0] d);
    if (wr) begin
      if (cyc >= last_stop) begin
        exp_st_cyc.push_back(cyc + 1);
        exp_st_q.push_back(DSR_BUSY);
        exp_fr_cyc.push_back(cyc + 2);
        exp_q.push_back(d);
        last_stop = cyc + 1 + FRAME_CYC;
      end else begin
        overrun_m = 1'b1;
      end
    end else if (cyc == last_stop) begin
      exp_st_cyc.push_back(cyc + 1);
      exp_st_q.push_back(DSR_READY);
    end
    i_ld_ddr = wr;
    if (!prev_wr) i_ddr = wr ? d : 8'($urandom);
    prev_wr = wr;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic reset_dut(input int n);
    i_Rst = 1'b1;
    i_ld_ddr = 1'b0;
    prev_wr = 1'b0;
    exp_st_cyc.delete();
    exp_st_q.delete();
    exp_fr_cyc.delete();
    exp_q.delete();
    last_stop = -1;
    overrun_m = 1'b0;
    repeat (n) begin
      tick();
      chk("rst_tx", o_tx, 1);
      chk("rst_busy", o_busy, 0);
      chk("rst_dsr", o_dsr_ext, 16'h8000);
      chk("rst_ld_dsr", o_ld_dsr_ext, 1);
      chk("rst_overrun", o_overrun, 0);
    end
    i_Rst = 1'b0;
    tick();
    chk("post_rst_ld_dsr", o_ld_dsr_ext, 0);
    chk("post_rst_tx", o_tx, 1);
    chk("post_rst_dsr", o_dsr_ext, 16'h8000);
  endtask

  // ---------------- monitors ----------------
  // DSR strobe monitor.
  always @(negedge i_Clk) begin
    if (!rst_at_edge && o_ld_dsr_ext) begin
      if (exp_st_q.size() == 0) begin
        chk("unexpected_strobe", o_dsr_ext, 16'hDEAD);
      end else begin
        chk("strobe_cycle", exp_st_cyc.pop_front(), cyc);
        chk("strobe_value", o_dsr_ext, exp_st_q.pop_front());
      end
    end
  end

  // Serial line monitor: finds the start edge and records 10 bits, each
  // required to be constant for CPB cycles with o_busy high.
  initial begin
    logic       prev;
    logic [9:0] obs;
    logic       ok;
    logic       aborted;
    int         s;
    prev = 1'b1;
    forever begin
      @(negedge i_Clk);
      if (rst_at_edge) begin
        prev = 1'b1;
      end else if (prev && !o_tx) begin
        s = cyc;
        obs = '0;
        ok = 1'b1;
        aborted = 1'b0;
        for (int k = 0; k < FRAME_CYC; k++) begin
          if (k > 0) @(negedge i_Clk);
          if (rst_at_edge) begin
            aborted = 1'b1;
            break;
          end
          if (k % CPB == 0) obs[k / CPB] = o_tx;
          else if (o_tx !== obs[k / CPB]) ok = 1'b0;
          if (o_busy !== 1'b1) ok = 1'b0;
        end
        if (aborted) begin
          prev = 1'b1;
        end else begin
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", {22'd0, obs}, 32'hFFFF);
          end else begin
            chk("frame_start_cycle", s, exp_fr_cyc.pop_front());
            chk("frame_bits", {22'd0, obs}, {22'd0, 1'b1, exp_q.pop_front(), 1'b0});
            chk("frame_stable_busy", ok, 1);
          end
          prev = o_tx;
        end
      end else begin
        prev = o_tx;
      end
    end
  end

  // ---------------- test sequence ----------------
  int w;
  initial begin
    // reset, then idle line
    reset_dut(3);
    idle(3);
    chk("idle_tx", o_tx, 1);
    chk("idle_busy", o_busy, 0);
    chk("idle_dsr", o_dsr_ext, 16'h8000);

    // single frame 0x41
    step(1'b1, 8'h41);
    chk("capture_busy", o_busy, 1);
    idle(50);
    chk("after_41_busy", o_busy, 0);
    chk("after_41_dsr_hold", o_dsr_ext, 16'h8000);
    chk("after_41_overrun", o_overrun, 0);

    // store dropped 10 cycles into a frame
    step(1'b1, 8'h41);
    idle(9);
    step(1'b1, 8'h55);
    chk("mid_frame_dsr", o_dsr_ext, 16'h0000);
    idle(45);
    chk("overrun_set", o_overrun, overrun_m);
    idle(5);
    chk("overrun_sticky", o_overrun, 1);

    // reset clears overrun; then store coincident with the last stop cycle
    reset_dut(2);
    chk("overrun_cleared", o_overrun, 0);
    w = cyc;
    step(1'b1, 8'hA3);
    while (cyc < w + 1 + FRAME_CYC) step(1'b0, 8'h00);
    step(1'b1, 8'h5A);
    chk("b2b_dsr", o_dsr_ext, 16'h0000);
    chk("b2b_busy", o_busy, 1);
    idle(50);
    chk("b2b_overrun", o_overrun, 0);

    // reset during data bit 3 of 0xFF aborts the frame
    w = cyc;
    step(1'b1, 8'hFF);
    while (cyc < w + 2 + 4 * CPB) step(1'b0, 8'h00);
    i_Rst = 1'b1;
    i_ld_ddr = 1'b0;
    tick();
    chk("abort_tx", o_tx, 1);
    chk("abort_busy", o_busy, 0);
    chk("abort_dsr", o_dsr_ext, 16'h8000);
    reset_dut(1);
    step(1'b1, 8'h3C);
    idle(50);

    // randomized stores: gaps, overruns and coincident back-to-back
    repeat (30) begin
      if ($urandom_range(0, 3) == 0 && last_stop >= cyc) begin
        while (cyc < last_stop) step(1'b0, 8'h00);
      end else begin
        idle($urandom_range(0, 45));
      end
      step(1'b1, 8'($urandom));
    end
    idle(60);
    chk("rand_overrun", o_overrun, overrun_m);
    chk("rand_busy_end", o_busy, 0);
    chk("rand_dsr_end", o_dsr_ext, 16'h8000);
    chk("frames_drained", exp_q.size(), 0);
    chk("strobes_drained", exp_st_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
